// File: rtl/idexe_skid_stage.sv
// rtl/idexe_skid_stage.sv - ID/EXE pipeline register with skid buffer, flush and perf counters
module idexe_skid_stage #(
    parameter int LEN    = 32,
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LEN-1:0]    pc,
    input  logic [LEN-1:0]    instruction,
    input  logic              wb_en,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        branch_type,
    input  logic [3:0]        exe_cmd,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] alu_inp1,
    input  logic [DATA_W-1:0] alu_inp2,
    input  logic [REG_W-1:0]  dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LEN-1:0]    pc_out,
    output logic [LEN-1:0]    instruction_out,
    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic [1:0]        branch_type_out,
    output logic [3:0]        exe_cmd_out,
    output logic [DATA_W-1:0] reg2_out,
    output logic [DATA_W-1:0] alu_inp1_out,
    output logic [DATA_W-1:0] alu_inp2_out,
    output logic [REG_W-1:0]  dest_out,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef struct packed {
        logic [LEN-1:0]    pc;
        logic [LEN-1:0]    instruction;
        logic              wb_en;
        logic              mem_read;
        logic              mem_write;
        logic [1:0]        branch_type;
        logic [3:0]        exe_cmd;
        logic [DATA_W-1:0] reg2;
        logic [DATA_W-1:0] alu_inp1;
        logic [DATA_W-1:0] alu_inp2;
        logic [REG_W-1:0]  dest;
    } entry_t;

    entry_t in_entry;
    entry_t main_entry;
    entry_t skid_entry;
    logic   main_valid;
    logic   skid_valid;
    logic   xfer_in;
    logic   xfer_out;
    logic   main_free;

    assign in_entry = '{
        pc:          pc,
        instruction: instruction,
        wb_en:       wb_en,
        mem_read:    mem_read,
        mem_write:   mem_write,
        branch_type: branch_type,
        exe_cmd:     exe_cmd,
        reg2:        reg2,
        alu_inp1:    alu_inp1,
        alu_inp2:    alu_inp2,
        dest:        dest
    };

    // in_ready comes straight off the skid valid flop, so out_ready never reaches it
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign xfer_in   = in_valid & in_ready;
    assign xfer_out  = main_valid & out_ready;
    // main can take a new entry this edge if it is empty or is being drained
    assign main_free = ~main_valid | xfer_out;

    // Valid bits: skid refills main first; otherwise the input fills main or, if main is held, skid
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (main_free) begin
                if (skid_valid) begin
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    main_valid <= xfer_in;
                end
            end
            if (xfer_in && !main_free) begin
                skid_valid <= 1'b1;
            end
        end
    end

    // Payload registers follow the valid bits; flushes leave the stale data in place
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_entry <= '0;
            skid_entry <= '0;
        end else if (!flush) begin
            if (main_free) begin
                if (skid_valid) begin
                    main_entry <= skid_entry;
                end else if (xfer_in) begin
                    main_entry <= in_entry;
                end
            end
            if (xfer_in && !main_free) begin
                skid_entry <= in_entry;
            end
        end
    end

    // Control fields become a bubble while main is empty; data fields keep their last value
    assign pc_out          = main_entry.pc;
    assign instruction_out = main_entry.instruction;
    assign wb_en_out       = main_valid & main_entry.wb_en;
    assign mem_read_out    = main_valid & main_entry.mem_read;
    assign mem_write_out   = main_valid & main_entry.mem_write;
    assign branch_type_out = main_valid ? main_entry.branch_type : 2'b00;
    assign exe_cmd_out     = main_entry.exe_cmd;
    assign reg2_out        = main_entry.reg2;
    assign alu_inp1_out    = main_entry.alu_inp1;
    assign alu_inp2_out    = main_entry.alu_inp2;
    assign dest_out        = main_entry.dest;

    // Saturating counters for back-pressure cycles and flushes that squashed something
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (main_valid && !out_ready && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (flush && (main_valid || skid_valid) && (flush_count != '1)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/idexe_skid_stage.md
IDEXE_SKID_STAGE -- requirements
Module: idexe_skid_stage

Interface
Parameters:
REQ-001 The block SHALL have parameter LEN, default 32, the width of pc and instruction.
REQ-002 The block SHALL have parameter DATA_W, default 32, the width of reg2, alu_inp1 and alu_inp2.
REQ-003 The block SHALL have parameter REG_W, default 5, the width of dest.
REQ-004 The block SHALL have parameter CNT_W, default 16, the width of the performance counters.
Ports:
REQ-005 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 in_valid  in  1  the ID stage presents an instruction; in_ready  out  1  the stage can accept it.
REQ-008 pc, instruction  in  LEN each; wb_en, mem_read, mem_write  in  1 each; branch_type  in  2; exe_cmd  in  4; reg2, alu_inp1, alu_inp2  in  DATA_W each; dest  in  REG_W.
REQ-009 flush  in  1  synchronous squash of all held and incoming instructions.
REQ-010 out_valid  out  1  the EXE stage is presented an instruction; out_ready  in  1  the EXE stage takes it.
REQ-011 pc_out, instruction_out, wb_en_out, mem_read_out, mem_write_out, branch_type_out, exe_cmd_out, reg2_out, alu_inp1_out, alu_inp2_out, dest_out  out  widths equal to the matching inputs.
REQ-012 stall_count  out  CNT_W  counts cycles with out_valid=1 and out_ready=0; flush_count  out  CNT_W  counts effective flushes.

Function
REQ-013 The block SHALL hold two entries: main (drives the *_out ports) and skid, each with a valid bit.
REQ-014 in_ready SHALL equal NOT skid_valid, taken directly from a register with no combinational path from out_ready.
REQ-015 A transfer in SHALL occur when in_valid=1 and in_ready=1; a transfer out SHALL occur when out_valid=1 and out_ready=1.
REQ-016 out_valid SHALL equal main_valid.
REQ-017 If main is empty, or a transfer out occurs, main SHALL load from skid when skid_valid=1, otherwise from the input when a transfer in occurs, otherwise main_valid SHALL clear.
REQ-018 A transfer in that does not load main SHALL load skid; skid SHALL clear when its contents move to main.
REQ-019 Latency SHALL be one cycle from a transfer in to out_valid when the stage is empty.
REQ-020 Throughput SHALL be one instruction per cycle while out_ready=1, and no instruction SHALL be dropped or duplicated.
REQ-021 Instruction order SHALL be preserved.
REQ-022 When main_valid=0, wb_en_out, mem_read_out, mem_write_out and branch_type_out SHALL be forced to 0 (bubble); data outputs SHALL hold their last values.
REQ-023 A flush SHALL clear main_valid and skid_valid at the next edge and discard any same-cycle input.
REQ-024 A flush SHALL have priority over every simultaneous transfer.
REQ-025 Flush SHALL not alter in_ready combinationally; in_ready SHALL be 1 in the cycle after the flush.
REQ-026 stall_count SHALL increment by 1 per stalled cycle and saturate at all-ones.
REQ-027 flush_count SHALL increment by 1 when flush=1 and (main_valid or skid_valid) and saturate at all-ones; a flush of an empty stage SHALL not count.
REQ-028 Flush SHALL not clear the counters.

Reset
REQ-029 Asserting reset SHALL immediately clear main_valid, skid_valid, every *_out, stall_count and flush_count to 0 and drive in_ready to 1.
REQ-030 Reset asserted mid-transfer SHALL discard all in-flight instructions; the first edge after release SHALL behave as from an empty stage.

Verification
REQ-031 Empty stage; in_valid=1, pc=0x100, out_ready=1 -> next cycle out_valid=1, pc_out=0x100; streaming 0x100,0x104,0x108 emerges in order with no gaps.
REQ-032 out_ready=0; send pc 0x200, then 0x204 -> main=0x200, skid=0x204, in_ready=0, stall_count increments each cycle; raise out_ready -> 0x200 then 0x204 delivered, in_ready returns to 1.
REQ-033 Both entries full, flush=1 with in_valid=1 (pc=0x300) -> next cycle out_valid=0, wb_en_out=mem_write_out=branch_type_out=0, in_ready=1, 0x300 never appears, flush_count=1.
REQ-034 Flush on an empty stage -> flush_count unchanged; hold out_ready=0 with valid data for 2^CNT_W+3 cycles (CNT_W=4) -> stall_count=15.
REQ-035 Reset asserted between edges with both entries full -> outputs 0 and in_ready=1 before the next edge; after release pc 0x400 passes with 1-cycle latency.
REQ-036 Random in_valid/out_ready/flush with a scoreboard model -> the output sequence equals the accepted sequence minus flushed entries, with no stall on the in_ready path.
